sprite_palette_bank: RTL and testbench

//   Writable, multi-palette successor to the fixed per-piece sprite palettes. Holds NUM_PAL palettes of
//   2**IDX_W RGB entries in double-buffered storage and serves pipelined colour lookups to the sprite

---
 rtl/palette_pkg.sv | 27 ++
 rtl/palette_dpram.sv | 28 ++
 rtl/sprite_palette_bank.sv | 178 +++++++++++++++++
 tb/tb_sprite_palette_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types for the sprite palette bank: default channel width, packed colour,
// piece palette ids, init FSM states and the grey-ramp initial value.
package palette_pkg;

    localparam int DEF_COLOR_W = 4;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] red;
        logic [DEF_COLOR_W-1:0] green;
        logic [DEF_COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        PAL_WP, PAL_BP, PAL_WN, PAL_BN, PAL_WB, PAL_BB, PAL_WR, PAL_BR
    } piece_pal_e;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    // Channel level of entry idx: low color_w bits of the index, zero-extended when narrower.
    function automatic int grey_ramp(input int idx, input int color_w);
        return idx & ((1 << color_w) - 1);
    endfunction

endpackage

// File: rtl/palette_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collision.
module palette_dpram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array and read register have no reset so they map onto block RAM;
    // the owner fills the contents after reset instead.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking, so a same-address read returns the pre-write contents.
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Double-buffered multi-palette colour lookup for the sprite renderer.
// Build macro PALETTE_TRANSPARENCY_EN adds the 'transparent' output (index 0 is the key colour).
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int  IDX_W   = 4,
    parameter int  NUM_PAL = 8,
    parameter int  COLOR_W = DEF_COLOR_W,
    localparam int PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    output logic                 busy,
    input  logic                 wr_en,
    input  logic [PAL_W-1:0]     wr_pal,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 commit,
    output logic                 swap_pending,
    input  logic                 rd_en,
    input  logic [PAL_W-1:0]     rd_pal,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
`ifdef PALETTE_TRANSPARENCY_EN
    output logic                 transparent,
`endif
    output logic [COLOR_W-1:0]   blue
);

    localparam int AW        = PAL_W + IDX_W;
    localparam int DW        = 3 * COLOR_W;
    localparam int INIT_LAST = NUM_PAL * (2**IDX_W) - 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            idle, init_we;
    logic            active_bank_q, active_bank_d, swap_pending_q, swap_pending_d, pend_now;
    logic            wr_ok;
    logic [1:0]      bank_we;
    logic [AW-1:0]   ram_wr_addr;
    logic [DW-1:0]   ram_wr_data;
    logic [COLOR_W-1:0] grey;
    logic [DW-1:0]   bank_rd [2];
    logic            s1_valid_q, s1_valid_d, s1_bank_q, s1_bank_d, s1_oor_q, s1_oor_d;
    logic [AW-1:0]   s1_addr_q, s1_addr_d;
    logic            s2_valid_q, s2_valid_d, s2_bank_q, s2_bank_d, s2_oor_q, s2_oor_d;
    logic [DW-1:0]   rgb_hold_q, rgb_hold_d, rgb_now, rgb_out;

    // Init FSM: state register, next state, outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // NOTE: every signal gets a default first, so no path through the block infers a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == AW'(INIT_LAST)) state_d = ST_IDLE;
        end
    end

    always_comb begin
        busy    = (state_q == ST_INIT);
        idle    = (state_q == ST_IDLE);
        init_we = busy;
    end

    // A commit in the frame_start cycle is consumed by that same edge.
    always_comb begin
        pend_now       = swap_pending_q | (commit & idle);
        active_bank_d  = active_bank_q;
        swap_pending_d = pend_now;
        if (frame_start && pend_now) begin
            active_bank_d  = ~active_bank_q;
            swap_pending_d = 1'b0;
        end
    end

    always_comb begin
        grey        = COLOR_W'(grey_ramp(32'(init_cnt_q[IDX_W-1:0]), COLOR_W));
        wr_ok       = idle & wr_en & (32'(wr_pal) < NUM_PAL);
        bank_we[0]  = init_we | (wr_ok & active_bank_q);
        bank_we[1]  = init_we | (wr_ok & ~active_bank_q);
        ram_wr_addr = init_we ? init_cnt_q : {wr_pal, wr_idx};
        ram_wr_data = init_we ? {3{grey}} : wr_rgb;
    end

    // One RAM per bank so the init walk fills both banks in the same cycle.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        palette_dpram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
            .clk     (Clk),
            .wr_en   (bank_we[b]),
            .wr_addr (ram_wr_addr),
            .wr_data (ram_wr_data),
            .rd_en   (s1_valid_q),
            .rd_addr (s1_addr_q),
            .rd_data (bank_rd[b])
        );
    end

    always_comb begin
        s1_valid_d = idle & rd_en;
        s1_addr_d  = {rd_pal, rd_idx};
        s1_bank_d  = active_bank_q;
        s1_oor_d   = (32'(rd_pal) >= NUM_PAL);
        s2_valid_d = s1_valid_q;
        s2_bank_d  = s1_bank_q;
        s2_oor_d   = s1_oor_q;
        rgb_now    = s2_oor_q ? '0 : bank_rd[s2_bank_q];
        rgb_hold_d = s2_valid_q ? rgb_now : rgb_hold_q;
        rgb_out    = s2_valid_q ? rgb_now : rgb_hold_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_addr_q      <= '0;
            s1_bank_q      <= 1'b0;
            s1_oor_q       <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_bank_q      <= 1'b0;
            s2_oor_q       <= 1'b0;
            rgb_hold_q     <= '0;
        end else begin
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            s1_valid_q     <= s1_valid_d;
            s1_addr_q      <= s1_addr_d;
            s1_bank_q      <= s1_bank_d;
            s1_oor_q       <= s1_oor_d;
            s2_valid_q     <= s2_valid_d;
            s2_bank_q      <= s2_bank_d;
            s2_oor_q       <= s2_oor_d;
            rgb_hold_q     <= rgb_hold_d;
        end
    end

`ifdef PALETTE_TRANSPARENCY_EN
    logic s1_key_q, s1_key_d, s2_key_q, s2_key_d;

    always_comb begin
        s1_key_d = (rd_idx == '0);
        s2_key_d = s1_key_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_key_q <= 1'b0;
            s2_key_q <= 1'b0;
        end else begin
            s1_key_q <= s1_key_d;
            s2_key_q <= s2_key_d;
        end
    end

    assign transparent = s2_valid_q & s2_key_q;
`endif

    assign rd_valid     = s2_valid_q;
    assign swap_pending = swap_pending_q;
    assign red          = rgb_out[3*COLOR_W-1:2*COLOR_W];
    assign green        = rgb_out[2*COLOR_W-1:COLOR_W];
    assign blue         = rgb_out[COLOR_W-1:0];

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: directed lookups push expected colours,
// a negedge monitor checks rd_valid every cycle and pops/compares each result.
module tb_sprite_palette_bank;
    import palette_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        busy;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_pal = '0;
    logic [3:0]  wr_idx = '0;
    logic [11:0] wr_rgb = '0;
    logic        commit = 1'b0;
    logic        swap_pending;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_pal = '0;
    logic [3:0]  rd_idx = '0;
    logic        rd_valid;
    logic [3:0]  red, green, blue;
`ifdef PALETTE_TRANSPARENCY_EN
    logic        transparent;
`endif

    sprite_palette_bank dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .busy         (busy),
        .wr_en        (wr_en),
        .wr_pal       (wr_pal),
        .wr_idx       (wr_idx),
        .wr_rgb       (wr_rgb),
        .commit       (commit),
        .swap_pending (swap_pending),
        .rd_en        (rd_en),
        .rd_pal       (rd_pal),
        .rd_idx       (rd_idx),
        .rd_valid     (rd_valid),
        .red          (red),
        .green        (green),
`ifdef PALETTE_TRANSPARENCY_EN
        .transparent  (transparent),
`endif
        .blue         (blue)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct {
        rgb_t rgb;
        logic key;
        int   issue;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: rd_valid must rise exactly two edges after each issued lookup.
    logic exp_valid;
    exp_t mon_e;
    always @(negedge Clk) begin
        exp_valid = (exp_q.size() > 0) && (exp_q[0].issue == cyc - 2);
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        if (exp_valid) begin
            mon_e = exp_q.pop_front();
            if (rd_valid) begin
                check("rgb", 32'({red, green, blue}), 32'(mon_e.rgb));
`ifdef PALETTE_TRANSPARENCY_EN
                check("transparent", 32'(transparent), 32'(mon_e.key));
`endif
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] pal, input logic [3:0] idx, input logic [11:0] rgb);
        exp_t e;
        rd_en  = 1'b1;
        rd_pal = pal;
        rd_idx = idx;
        e.rgb   = rgb;
        e.key   = (idx == 4'd0);
        e.issue = cyc;
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    task automatic write(input logic [2:0] pal, input logic [3:0] idx, input logic [11:0] rgb);
        wr_en  = 1'b1;
        wr_pal = pal;
        wr_idx = idx;
        wr_rgb = rgb;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit(input logic with_frame);
        commit      = 1'b1;
        frame_start = with_frame;
        step();
        commit      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Counts busy cycles; optionally pokes write/commit/read/frame_start mid-init.
    task automatic wait_init(input logic poke);
        int n = 0;
        while (busy && n < 300) begin
            rd_en       = poke && n >= 20 && n < 30;
            wr_en       = rd_en;
            commit      = rd_en;
            frame_start = poke && n == 25;
            wr_pal = 3'd0; wr_idx = 4'd0; wr_rgb = 12'hFFF;
            rd_pal = 3'd0; rd_idx = 4'd0;
            step();
            n++;
        end
        rd_en = 1'b0; wr_en = 1'b0; commit = 1'b0; frame_start = 1'b0;
        check("busy_cycles", 32'(n), 32'd128);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_pending", 32'(swap_pending), 32'd0);
        check("reset_rgb", 32'({red, green, blue}), 32'h000);
`ifdef PALETTE_TRANSPARENCY_EN
        check("reset_transparent", 32'(transparent), 32'd0);
`endif
        Reset_n = 1'b1;
        wait_init(1'b1);
        check("pending_after_init", 32'(swap_pending), 32'd0);

        // Grey ramp after init and output hold.
        issue(PAL_BN, 4'd5, 12'h555);
        issue(PAL_WP, 4'd0, 12'h000);
        issue(PAL_BR, 4'd15, 12'hFFF);
        repeat (4) step();
        check("hold_rgb", 32'({red, green, blue}), 32'hFFF);

        // Shadow write visible only after commit + frame_start.
        write(PAL_BP, 4'd2, 12'hA0B);
        issue(PAL_BP, 4'd2, 12'h222);
        pulse_commit(1'b1);
        check("pending_same_cycle_swap", 32'(swap_pending), 32'd0);
        issue(PAL_BP, 4'd2, 12'hA0B);
        issue(PAL_WP, 4'd0, 12'h000);
        issue(PAL_BP, 4'd3, 12'h333);

        // Commit waits for frame_start.
        pulse_commit(1'b0);
        check("pending_set", 32'(swap_pending), 32'd1);
        repeat (100) step();
        check("pending_held", 32'(swap_pending), 32'd1);
        issue(PAL_BP, 4'd2, 12'hA0B);
        pulse_frame();
        check("pending_cleared", 32'(swap_pending), 32'd0);
        issue(PAL_BP, 4'd2, 12'h222);
        pulse_frame();
        check("pending_idle_frame", 32'(swap_pending), 32'd0);
        issue(PAL_BP, 4'd2, 12'h222);

        // Back-to-back lookups across a full palette.
        for (int i = 0; i < 16; i++) issue(PAL_WN, 4'(i), {3{4'(i)}});

        // Lookup and write in the swap cycle see the pre-swap banks.
        write(PAL_WB, 4'd7, 12'h123);
        pulse_commit(1'b0);
        check("pending_before_swap", 32'(swap_pending), 32'd1);
        frame_start = 1'b1;
        wr_en = 1'b1; wr_pal = PAL_WB; wr_idx = 4'd8; wr_rgb = 12'h456;
        issue(PAL_WB, 4'd7, 12'h777);
        frame_start = 1'b0;
        wr_en = 1'b0;
        check("pending_after_swap", 32'(swap_pending), 32'd0);
        issue(PAL_WB, 4'd7, 12'h123);
        issue(PAL_WB, 4'd8, 12'h456);

        // Reset in the middle of a lookup stream.
        pulse_commit(1'b0);
        check("pending_before_reset", 32'(swap_pending), 32'd1);
        issue(PAL_WN, 4'd3, 12'h333);
        issue(PAL_WN, 4'd4, 12'h444);
        check("valid_before_reset", 32'(rd_valid), 32'd1);
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_pending_lost", 32'(swap_pending), 32'd0);
        check("reset_busy_again", 32'(busy), 32'd1);
        check("reset_rgb_again", 32'({red, green, blue}), 32'h000);
        repeat (2) step();
        Reset_n = 1'b1;
        wait_init(1'b0);
        pulse_commit(1'b1);
        issue(PAL_WB, 4'd7, 12'h777);
        issue(PAL_WB, 4'd8, 12'h888);
        issue(PAL_BB, 4'd0, 12'h000);
        issue(PAL_BB, 4'd1, 12'h111);

        repeat (5) step();
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
